gray_step_monitor: RTL and testbench

Downstream consumer of the 4-bit Gray code counter. Each cycle it samples the Gray word, decodes it to binary, and checks that consecutive samples form a legal counting sequence. It reports lock status, a one-cycle step-error pulse and a saturating error count, so the counter's output integrity can be observed in system and in test.

---
 rtl/gray_mon_pkg.sv | 34 +++
 rtl/gray_to_bin.sv | 16 +
 rtl/gray_step_monitor.sv | 153 +++++++++++++++
 tb/tb_gray_step_monitor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/gray_mon_pkg.sv
// Shared types and helpers for the Gray-code step monitor.
// Provides the monitor state enum and a width-parameterised Gray-to-binary decode.
package gray_mon_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } mon_state_e;

  // Widest word gray2bin handles; callers zero-extend into this width.
  localparam int unsigned GRAY_MAX_W = 32;

  // Decodes the low w bits of g. Each binary bit is the XOR of its Gray bit and
  // every more-significant Gray bit, which is the recursive
  // bin[i] = bin[i+1] ^ g[i] definition unrolled. Bits at or above w are ignored.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(
    input logic [GRAY_MAX_W-1:0] g,
    input int unsigned           w
  );
    logic [GRAY_MAX_W-1:0] mask;
    logic [GRAY_MAX_W-1:0] gm;
    logic [GRAY_MAX_W-1:0] b;
    mask = '1;
    if (w < GRAY_MAX_W) mask = ~(mask << w);
    gm = g & mask;
    b  = '0;
    for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
      b[i] = ^(gm >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational Gray-to-binary decoder, WIDTH bits wide.
module gray_to_bin
  import gray_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Decode through the shared package helper.
  always_comb begin
    bin_o = WIDTH'(gray2bin(GRAY_MAX_W'(gray_i), WIDTH));
  end

endmodule

// File: rtl/gray_step_monitor.sv
// Gray-code step monitor: decodes each valid Gray sample, checks that successive
// samples hold or count up by one (mod 2^WIDTH), and reports lock, a one-cycle
// step-error pulse and a saturating error count.
// Optional feature macro GRAY_MON_DOWN_EN: also accept down-by-one steps and
// report their direction on dir; when undefined, down-steps are errors and dir is 0.
module gray_step_monitor
  import gray_mon_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 valid_in,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 locked,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 dir
);

  localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);

  mon_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic                 bv_q, bv_d;
  logic                 se_q, se_d;
  logic [ERR_CNT_W-1:0] ec_q, ec_d;

  logic [WIDTH-1:0]     n;
  logic [WIDTH-1:0]     p_inc;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 is_hold;
  logic                 is_up;
  logic                 is_good;
  logic                 lock_hit;

  gray_to_bin #(
    .WIDTH(WIDTH)
  ) u_dec (
    .gray_i(gray_in),
    .bin_o (n)
  );

`ifdef GRAY_MON_DOWN_EN
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] p_dec;
  logic             is_down;
`endif

  // Classify the new sample against the previous decoded value.
  always_comb begin
    p_inc    = bin_q + WIDTH'(1);
    cnt_inc  = cnt_q + CNT_W'(1);
    is_hold  = (n == bin_q);
    is_up    = (n == p_inc);
    lock_hit = (cnt_inc == CNT_W'(LOCK_COUNT));
`ifdef GRAY_MON_DOWN_EN
    p_dec    = bin_q - WIDTH'(1);
    is_down  = (n == p_dec);
    is_good  = is_up | is_down;
`else
    is_good  = is_up;
`endif
  end

  // Next-state, good-step counter and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bv_d    = 1'b0;
    se_d    = 1'b0;
    ec_d    = ec_q;
`ifdef GRAY_MON_DOWN_EN
    dir_d   = dir_q;
`endif
    if (valid_in) begin
      bin_d = n;
      bv_d  = 1'b1;
      case (state_q)
        UNLOCKED: begin
          state_d = ACQUIRE;
          cnt_d   = '0;
        end
        ACQUIRE: begin
          if (is_good) begin
            cnt_d = cnt_inc;
            if (lock_hit) state_d = LOCKED;
          end else if (!is_hold) begin
            cnt_d = '0;
          end
        end
        LOCKED: begin
          if (!is_good && !is_hold) begin
            se_d    = 1'b1;
            cnt_d   = '0;
            state_d = ACQUIRE;
            if (ec_q != '1) ec_d = ec_q + ERR_CNT_W'(1);
          end
        end
        default: begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end
      endcase
`ifdef GRAY_MON_DOWN_EN
      if (state_q != UNLOCKED && is_good) dir_d = is_down;
`endif
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= UNLOCKED;
      cnt_q   <= '0;
      bin_q   <= '0;
      bv_q    <= 1'b0;
      se_q    <= 1'b0;
      ec_q    <= '0;
`ifdef GRAY_MON_DOWN_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bv_q    <= bv_d;
      se_q    <= se_d;
      ec_q    <= ec_d;
`ifdef GRAY_MON_DOWN_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = bv_q;
  assign locked    = (state_q == LOCKED);
  assign step_err  = se_q;
  assign err_count = ec_q;
`ifdef GRAY_MON_DOWN_EN
  assign dir       = dir_q;
`else
  assign dir       = 1'b0;
`endif

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed, table-driven bench for gray_step_monitor, plus a saturation sequence
// on a second instance with a 2-bit error counter.
module tb_gray_step_monitor;

`ifdef GRAY_MON_DOWN_EN
  localparam bit DN = 1'b1;
`else
  localparam bit DN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] gray_in;
  logic       valid_in;

  logic [3:0] bin_out, bin_out2;
  logic       bin_valid, bin_valid2;
  logic       locked, locked2;
  logic       step_err, step_err2;
  logic [7:0] err_count;
  logic [1:0] err_count2;
  logic       dir, dir2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gray_step_monitor #(
    .WIDTH(4), .LOCK_COUNT(2), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .gray_in(gray_in), .valid_in(valid_in),
    .bin_out(bin_out), .bin_valid(bin_valid), .locked(locked),
    .step_err(step_err), .err_count(err_count), .dir(dir)
  );

  gray_step_monitor #(
    .WIDTH(4), .LOCK_COUNT(2), .ERR_CNT_W(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .gray_in(gray_in), .valid_in(valid_in),
    .bin_out(bin_out2), .bin_valid(bin_valid2), .locked(locked2),
    .step_err(step_err2), .err_count(err_count2), .dir(dir2)
  );

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [3:0] gray;
    logic [3:0] bin;
    logic       bv;
    logic       lk;
    logic       se;
    logic [7:0] ec;
    logic       dir;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [3:0] g,
                              input logic [3:0] b, input logic bv, input logic lk,
                              input logic se, input logic [7:0] ec, input logic d);
    vec_t x;
    x.rst_n = r; x.valid = v; x.gray = g; x.bin = b; x.bv = bv;
    x.lk = lk; x.se = se; x.ec = ec; x.dir = d;
    return x;
  endfunction

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] g);
    @(negedge clk);
    reset    = r;
    valid_in = v;
    gray_in  = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] p;
    logic [7:0] ec_after_skip;
    reset    = 1'b0;
    valid_in = 1'b0;
    gray_in  = 4'h0;

    ec_after_skip = DN ? 8'd2 : 8'd1;

    //                r  v  gray   bin   bv  lk  se  ec  dir
    tbl.push_back(mk(0, 0, 4'h0, 4'd0,  0,  0,  0, 8'd0, 0));   // reset
    tbl.push_back(mk(0, 1, 4'h5, 4'd0,  0,  0,  0, 8'd0, 0));   // reset beats valid
    tbl.push_back(mk(1, 1, 4'h0, 4'd0,  1,  0,  0, 8'd0, 0));   // seed
    tbl.push_back(mk(1, 1, 4'h0, 4'd0,  1,  0,  0, 8'd0, 0));   // hold
    tbl.push_back(mk(1, 1, 4'h1, 4'd1,  1,  0,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h3, 4'd2,  1,  1,  0, 8'd0, 0));   // lock
    tbl.push_back(mk(1, 1, 4'h2, 4'd3,  1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h6, 4'd4,  1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h7, 4'd5,  1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h5, 4'd6,  1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h4, 4'd7,  1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'hC, 4'd8,  1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'hD, 4'd9,  1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'hF, 4'd10, 1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'hE, 4'd11, 1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'hA, 4'd12, 1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'hB, 4'd13, 1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h9, 4'd14, 1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h8, 4'd15, 1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h0, 4'd0,  1,  1,  0, 8'd0, 0));   // wrap 15->0
    tbl.push_back(mk(1, 1, 4'h1, 4'd1,  1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h3, 4'd2,  1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h2, 4'd3,  1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h4, 4'd7,  1,  0,  1, 8'd1, 0));   // skip 3->7
    tbl.push_back(mk(1, 1, 4'h5, 4'd6,  1,  0,  0, 8'd1, DN));  // 7->6
    tbl.push_back(mk(1, 1, 4'h7, 4'd5,  1, DN,  0, 8'd1, DN));  // 6->5
    tbl.push_back(mk(1, 1, 4'h4, 4'd7,  1,  0, DN, ec_after_skip, DN)); // 5->7
    tbl.push_back(mk(1, 1, 4'hC, 4'd8,  1,  0,  0, ec_after_skip, 0));
    tbl.push_back(mk(1, 1, 4'hD, 4'd9,  1,  1,  0, ec_after_skip, 0)); // relock
    tbl.push_back(mk(0, 1, 4'hF, 4'd0,  0,  0,  0, 8'd0, 0));   // reset mid-lock
    tbl.push_back(mk(1, 1, 4'h0, 4'd0,  1,  0,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h1, 4'd1,  1,  0,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h3, 4'd2,  1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h2, 4'd3,  1,  1,  0, 8'd0, 0));
    tbl.push_back(mk(1, 1, 4'h3, 4'd2,  1, DN, !DN, {7'd0, !DN}, DN)); // down 3->2
    tbl.push_back(mk(1, 0, 4'h7, 4'd2,  0, DN,  0, {7'd0, !DN}, DN));  // gated
    tbl.push_back(mk(1, 0, 4'hC, 4'd2,  0, DN,  0, {7'd0, !DN}, DN));
    tbl.push_back(mk(1, 0, 4'h0, 4'd2,  0, DN,  0, {7'd0, !DN}, DN));
    tbl.push_back(mk(1, 1, 4'h2, 4'd3,  1, DN,  0, {7'd0, !DN}, 0));   // 2->3

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].valid, tbl[i].gray);
      chk($sformatf("v%0d.bin_out", i),   32'(bin_out),   32'(tbl[i].bin));
      chk($sformatf("v%0d.bin_valid", i), 32'(bin_valid), 32'(tbl[i].bv));
      chk($sformatf("v%0d.locked", i),    32'(locked),    32'(tbl[i].lk));
      chk($sformatf("v%0d.step_err", i),  32'(step_err),  32'(tbl[i].se));
      chk($sformatf("v%0d.err_count", i), 32'(err_count), 32'(tbl[i].ec));
      chk($sformatf("v%0d.dir", i),       32'(dir),       32'(tbl[i].dir));
    end

    // Five lock/error cycles: the 2-bit counter must stick at 3.
    drive(1'b0, 1'b0, 4'h0);
    p = 4'd0;
    drive(1'b1, 1'b1, bin2gray(p));
    for (int i = 0; i < 5; i++) begin
      p = p + 4'd1;
      drive(1'b1, 1'b1, bin2gray(p));
      p = p + 4'd1;
      drive(1'b1, 1'b1, bin2gray(p));
      chk($sformatf("sat%0d.locked", i), 32'(locked2), 32'd1);
      p = p + 4'd5;
      drive(1'b1, 1'b1, bin2gray(p));
      chk($sformatf("sat%0d.step_err", i),   32'(step_err2),  32'd1);
      chk($sformatf("sat%0d.err_count2", i), 32'(err_count2), (i < 3) ? 32'(i + 1) : 32'd3);
      chk($sformatf("sat%0d.err_count8", i), 32'(err_count),  32'(i + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
